// File: rtl/imem_pkg.sv
// Shared types and the power-on image for the LED CPU program memory.
// The optional checksum stage is selected by the IMEM_CHECKSUM_EN macro.
package imem_pkg;

    localparam int IMEM_DEPTH = 16;
    localparam int IMEM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_CSUM = 2'd2,
        ST_ERR  = 2'd3
    } imem_state_t;

    // Index 0 is the rightmost element: MVI 1; MOV r6,r0; INC r0; JMP 1.
    localparam logic [IMEM_DEPTH-1:0][IMEM_DATA_W-1:0] DEFAULT_PROG =
        {{12{8'h00}}, 8'h91, 8'h60, 8'h30, 8'hA1};

endpackage

// File: rtl/imem_array.sv
// 16x8 instruction storage: asynchronous read, synchronous write,
// synchronous reload of the default program while reset is low.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DEFAULT_PROG[i];
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// Program-memory responder with in-system byte-stream reload; holds the CPU
// in reset while loading. IMEM_CHECKSUM_EN adds a trailing checksum byte.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] adr,
    output logic [7:0]               dout,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic [7:0]               ld_data,
    output logic                     ld_ready,
    output logic                     cpu_reset,
    output logic                     busy,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);

    imem_state_t   r_state;
    logic [AW-1:0] r_ptr;
    logic          r_cpu_reset;
    logic          w_we;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]    r_acc;
`endif

    // A byte offered in the same cycle as ld_start is dropped.
    assign w_we = (r_state == ST_LOAD) && ld_valid && !ld_start;

    imem_array #(.DEPTH(DEPTH), .DATA_W(8)) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (r_ptr),
        .i_wdata (ld_data),
        .i_raddr (adr),
        .o_rdata (dout)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_ptr       <= '0;
            r_cpu_reset <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            r_acc       <= 8'h00;
`endif
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ld_start) begin
                        r_state     <= ST_LOAD;
                        r_ptr       <= '0;
                        r_cpu_reset <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                        r_acc       <= 8'h00;
`endif
                    end else begin
                        r_cpu_reset <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ld_start) begin
                        r_ptr <= '0;
`ifdef IMEM_CHECKSUM_EN
                        r_acc <= 8'h00;
`endif
                    end else if (ld_valid) begin
                        r_ptr <= r_ptr + 1'b1;
`ifdef IMEM_CHECKSUM_EN
                        r_acc <= r_acc + ld_data;
                        if (r_ptr == AW'(DEPTH - 1)) begin
                            r_state <= ST_CSUM;
                        end
`else
                        if (r_ptr == AW'(DEPTH - 1)) begin
                            r_state     <= ST_RUN;
                            r_cpu_reset <= 1'b1;
                        end
`endif
                    end
                end
`ifdef IMEM_CHECKSUM_EN
                ST_CSUM: begin
                    if (ld_start) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                        r_acc   <= 8'h00;
                    end else if (ld_valid) begin
                        if (8'(r_acc + ld_data) == 8'h00) begin
                            r_state     <= ST_RUN;
                            r_cpu_reset <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                        end
                    end
                end
                ST_ERR: begin
                    if (ld_start) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                        r_acc   <= 8'h00;
                    end
                end
`endif
                default: begin
                    r_state     <= ST_RUN;
                    r_ptr       <= '0;
                    r_cpu_reset <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready  = (r_state == ST_LOAD) || (r_state == ST_CSUM);
    assign busy      = (r_state != ST_RUN);
    assign cpu_reset = r_cpu_reset;
`ifdef IMEM_CHECKSUM_EN
    assign err = (r_state == ST_ERR);
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Program-memory responder for the 4-bit LED CPU: serves the 8-bit instruction word for the CPU's 4-bit fetch address, and accepts an in-system reload of all 16 words over a valid/ready byte stream. While a reload is in progress, the CPU is held in reset. The block sits between the CPU's `adr`/`dout` fetch port and a host byte source such as a UART receiver or button loader.

## Interface
Parameters:
- `DEPTH`, 16, number of instruction words; must equal 2^width(`adr`).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `adr`  in  4  CPU fetch address.
- `dout`  out  8  instruction word at `adr`.
- `ld_start`  in  1  single-cycle pulse; begins or restarts a reload.
- `ld_valid`  in  1  `ld_data` is valid.
- `ld_data`  in  8  load byte.
- `ld_ready`  out  1  block accepts a byte this cycle.
- `cpu_reset`  out  1  active-low reset to the CPU.
- `busy`  out  1  a reload is in progress.
- `err`  out  1  checksum failure; tied 0 when `IMEM_CHECKSUM_EN` is undefined.

## Operation
States: RUN, LOAD, CSUM (macro only), ERR (macro only).

**Reset** (`reset`=0 at a clock edge):
- All 16 words are set to `DEFAULT_PROG`.
- State becomes RUN and the write pointer becomes 0.
- Outputs: `cpu_reset`=0, `ld_ready`=0, `busy`=0, `err`=0.
- Reset asserted during a load aborts the load; no partial image survives.

**Read path:**
- `dout` = `mem[adr]`, combinational, in every state.
- A word written at edge N is visible on `dout` after edge N.

**RUN:**
- `ld_ready`=0; `ld_valid` is ignored.
- `ld_start` moves the block to LOAD and sets the pointer to 0.

**LOAD:**
- `ld_ready`=1. A byte is accepted when `ld_valid`&&`ld_ready`: `mem[ptr]`<=`ld_data`, and `ptr` is incremented.
- `ld_valid` gaps are allowed.
- Accepting the 16th byte (ptr=15) moves the block to RUN, or to CSUM when the macro is defined.
- `ld_start` in LOAD sets `ptr` to 0 and discards any byte offered that cycle. Words already written keep their new values.

**CSUM:**
- The next accepted byte is the checksum.
- If (sum of the 16 bytes + checksum) mod 256 == 0, go to RUN; otherwise go to ERR.

**ERR:**
- `err`=1, `ld_ready`=0, CPU stays in reset.
- `ld_start` clears `err` and moves to LOAD. No other exit except `reset`.

**Outputs:**
- `busy` = state != RUN.
- `cpu_reset` is registered from the next state: it is 1 iff next state is RUN and `reset`=1.

## Timing
- `ld_start` sampled at edge N: `cpu_reset`=0, `busy`=1 and `ld_ready`=1 from edge N onward. The first byte can be accepted at edge N+1.
- Last byte (or checksum) accepted at edge M: `cpu_reset`=1 and `busy`=0 after edge M. The CPU fetches address 0 first after release.
- Write latency 1 cycle; read latency 0.
- Pointer arithmetic is 4-bit. It never wraps during LOAD because the 16th write exits the state.
- Checksum accumulator is 8-bit, wrap-around, cleared on each `ld_start`.

## Configuration
- `IMEM_CHECKSUM_EN` defined: CSUM and ERR states exist, one trailing checksum byte is required, and `err` is live.
- Undefined: the load is exactly 16 bytes, LOAD goes straight to RUN, `err`=0 constantly, and no accumulator is built.

## Structure
Package `imem_pkg` holds:
- `imem_state_t` enum.
- `IMEM_DEPTH`=16.
- `DEFAULT_PROG` (16×8) = {8'hA1, 8'h30, 8'h60, 8'h91, 8'h00 ×12}. This is the LED counter program: MVI 1; MOV r6,r0; INC r0; JMP 1.

Sub-module `imem_array`:
- 16×8 storage with asynchronous read and synchronous write.
- Synchronous load of `DEFAULT_PROG` on reset.
- The FSM, pointer and checksum stay in `imem_loader`.

## Test plan
- **Reset defaults:** hold `reset`=0 for 3 cycles, then release. Sweep `adr`=0..4 → `dout` = A1, 30, 60, 91, 00. `cpu_reset`=0 during reset and 1 after the first edge with `reset`=1.
- **Full reload with gaps:** pulse `ld_start`, then send 0x10..0x1F with random `ld_valid` gaps. Expect `cpu_reset`=0 and `busy`=1 throughout. After the 16th byte, `cpu_reset`=1 and `adr`=5 → `dout`=0x15.
- **Restart mid-load:** pulse `ld_start`, send 7 bytes 0xE0..0xE6, pulse `ld_start` with `ld_valid`=1 and data 0xFF, then send 0x40..0x4F. Expect the 0xFF byte is not written and `mem[k]`=0x40+k.
- **Ignored traffic in RUN:** assert `ld_valid`=1 with 0x55 for 10 cycles in RUN. Expect `ld_ready`=0 and memory unchanged (`adr`=0 → A1).
- **Checksum (macro):** send 16×0x01 with checksum 0xF0 → RUN, `err`=0. Send 16×0x01 with checksum 0xF1 → `err`=1, `cpu_reset` held 0. A following `ld_start` clears `err`.
- **Reset mid-load:** assert `reset`=0 after 5 bytes. Expect state RUN, `adr`=0 → A1, `busy`=0.
